// File: rtl/d_mem_generic_pkg.sv
// Shared definitions for the generic data-tape memory.
// Holds the access-direction encoding used on d_dir, the controller state
// encodings and a helper that sizes the RAM index.
package d_mem_generic_pkg;

  // Access direction carried on d_dir
  localparam logic DIRECTION_WRITE = 1'b1;
  localparam logic DIRECTION_READ  = 1'b0;

  // Controller states
  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } d_mem_state_t;

  // Index width needed to address 'depth' cells (never below 1 bit)
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/d_mem_generic_ram.sv
// Single-port synchronous RAM for the data tape.
// Ports:
//   clk, rst_n  clock and async active-low reset (read registers only)
//   we          write enable, writes wdata to addr
//   re          read enable, captures mem[addr] (or zero) into the read register
//   zero        forces the captured read value to 0 (out-of-range read)
//   addr        cell index
//   wdata       write data
//   rdata       read data, READ_LATENCY cycles after re, held between reads
module d_mem_generic_ram #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned IDX_W        = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic              zero,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  // Array write port; the array is deliberately left without reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // First read register, only updated by reads so it holds between accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (re) begin
      rd_q <= zero ? '0 : mem[addr];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic              re_d;
      logic [DATA_W-1:0] out_q;

      // Output register follows the read register one cycle later
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          re_d  <= 1'b0;
          out_q <= '0;
        end else begin
          re_d <= re;
          if (re_d) begin
            out_q <= rd_q;
          end
        end
      end

      assign rdata = out_q;
    end else begin : g_lat1
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: rtl/d_mem_generic.sv
// Parametrised data-tape memory controller for the bfcpu data port.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   d_req       access request, held with dir/addr/wdata until d_ack
//   d_dir       DIRECTION_WRITE selects a write, anything else a read
//   d_addr      cell address
//   d_wdata     write data
//   d_ack       one-cycle completion pulse
//   d_rdata     read data, valid with d_ack of a read and held afterwards
//   d_busy      zero-fill in progress, requests are left pending
//   d_err       pulses with d_ack when d_addr >= D_MEM_LENGTH
module d_mem_generic
  import d_mem_generic_pkg::*;
#(
  parameter int unsigned D_ADDR_WIDTH   = 8,
  parameter int unsigned D_DATA_WIDTH   = 8,
  parameter int unsigned D_MEM_LENGTH   = 256,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    d_req,
  input  logic                    d_dir,
  input  logic [D_ADDR_WIDTH-1:0] d_addr,
  input  logic [D_DATA_WIDTH-1:0] d_wdata,
  output logic                    d_ack,
  output logic [D_DATA_WIDTH-1:0] d_rdata,
  output logic                    d_busy,
  output logic                    d_err
);

  localparam int unsigned IDX_W = idx_width(D_MEM_LENGTH);
  // One extra bit so a full 2^D_ADDR_WIDTH clear terminates without wrapping
  localparam int unsigned CNT_W = D_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(D_MEM_LENGTH - 1);
  localparam logic [CNT_W-1:0] MEM_LEN   = CNT_W'(D_MEM_LENGTH);
  localparam d_mem_state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam d_mem_state_t READ_NEXT   = (READ_LATENCY == 2) ? ST_ACCESS : ST_ACK;

  d_mem_state_t      state, state_next;
  logic [CNT_W-1:0]  clr_cnt, clr_next;
  logic              err_q, err_next;

  logic                    in_range_c;
  logic                    ram_we_c;
  logic                    ram_re_c;
  logic                    ram_zero_c;
  logic [IDX_W-1:0]        ram_addr_c;
  logic [D_DATA_WIDTH-1:0] ram_wdata_c;

  assign in_range_c = {1'b0, d_addr} < MEM_LEN;

  // State, clear counter, latched error and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
      err_q   <= 1'b0;
      d_ack   <= 1'b0;
      d_err   <= 1'b0;
      d_busy  <= CLEAR_ON_RESET;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_next;
      err_q   <= err_next;
      d_ack   <= (state_next == ST_ACK);
      d_err   <= (state_next == ST_ACK) && err_next;
      d_busy  <= (state_next == ST_CLEAR);
    end
  end

  // Next state and RAM port control
  always_comb begin
    state_next  = state;
    clr_next    = clr_cnt;
    err_next    = err_q;
    ram_we_c    = 1'b0;
    ram_re_c    = 1'b0;
    ram_zero_c  = 1'b0;
    ram_addr_c  = IDX_W'(d_addr);
    ram_wdata_c = d_wdata;

    case (state)
      ST_CLEAR: begin
        ram_we_c    = 1'b1;
        ram_addr_c  = IDX_W'(clr_cnt);
        ram_wdata_c = '0;
        clr_next    = clr_cnt + CNT_W'(1);
        if (clr_cnt == LAST_CELL) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (d_req) begin
          err_next = ~in_range_c;
          if (d_dir == DIRECTION_WRITE) begin
            // Out-of-range writes keep full timing but never touch the array
            ram_we_c   = in_range_c;
            state_next = ST_ACK;
          end else begin
            ram_re_c   = 1'b1;
            ram_zero_c = ~in_range_c;
            state_next = READ_NEXT;
          end
        end
      end
      ST_ACCESS: begin
        state_next = ST_ACK;
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  d_mem_generic_ram #(
    .DEPTH        (D_MEM_LENGTH),
    .DATA_W       (D_DATA_WIDTH),
    .IDX_W        (IDX_W),
    .READ_LATENCY (READ_LATENCY)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_c),
    .re    (ram_re_c),
    .zero  (ram_zero_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (d_rdata)
  );

endmodule
